// File: rtl/fifo_thresh.sv
// -----------------------------------------------------------------------------
// fifo_thresh
//   Synchronous first-word-fall-through FIFO with occupancy thresholds and
//   registered overflow/underflow error pulses.
//
//   Ports
//     clk           sole clock, rising edge
//     reset         asynchronous, active-low reset
//     clear         synchronous flush, active-high, overrides push/pop
//     in            write data, sampled with push
//     push          write request
//     pop           read request
//     out           head-of-queue data, zero when empty
//     full          count == DEPTH
//     empty         count == 0
//     almost_full   count >= AF_LEVEL
//     almost_empty  count <= AE_LEVEL
//     count         current occupancy, 0..DEPTH
//     overflow      one-cycle pulse after a rejected push
//     underflow     one-cycle pulse after a rejected pop
// -----------------------------------------------------------------------------
module fifo_thresh #(
   parameter int DEPTH    = 4,
   parameter int WIDTH    = 2,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         in,
   input  logic                     push,
   input  logic                     pop,
   output logic [WIDTH-1:0]         out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          overflow_q,  overflow_d;
   logic          underflow_q, underflow_d;

   logic full_w;
   logic empty_w;
   logic push_ok;
   logic pop_ok;

   // Flags come from the registered count only, never from this cycle's requests.
   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);

   // A push at full is still taken when a pop frees the head slot on the same
   // edge; the pop side reads before the write lands, so no data is lost.
   // A pop never bypasses a push into an empty queue.
   assign pop_ok  = pop  & ~empty_w;
   assign push_ok = push & (~full_w | pop);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         overflow_d  = push & full_w & ~pop;
         underflow_d = pop & empty_w;

         // DEPTH is a power of two, so pointer wrap is plain modular overflow.
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end

         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset; stale words are never visible because out is
   // masked while empty and pointers restart at zero.
   always_ff @(posedge clk) begin
      if (!clear && push_ok) begin
         mem_q[wr_ptr_q] <= in;
      end
   end

   assign out          = empty_w ? '0 : mem_q[rd_ptr_q];
   assign full         = full_w;
   assign empty        = empty_w;
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_thresh.sv
module tb_fifo_thresh;

   localparam int DEPTH = 4;
   localparam int WIDTH = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic [WIDTH-1:0] din;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] dout;
   logic             full, empty, af, ae, ovf, unf;
   logic [2:0]       cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a plain queue plus the two error flags.
   logic [WIDTH-1:0] mq[$];
   logic             m_ovf = 1'b0;
   logic             m_unf = 1'b0;

   always #5 clk = ~clk;

   fifo_thresh dut (
      .clk         (clk),
      .reset       (reset),
      .clear       (clear),
      .in          (din),
      .push        (push),
      .pop         (pop),
      .out         (dout),
      .full        (full),
      .empty       (empty),
      .almost_full (af),
      .almost_empty(ae),
      .count       (cnt),
      .overflow    (ovf),
      .underflow   (unf)
   );

   // Applies one cycle of stimulus (called at a falling edge), advances the
   // model at the rising edge and returns at the next falling edge.
   task automatic cycle(input logic p, input logic o, input logic c, input logic [WIDTH-1:0] d);
      int sz;
      push = p; pop = o; clear = c; din = d;
      @(posedge clk);
      sz = mq.size();
      if (c) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         m_unf = o && (sz == 0);
         m_ovf = p && (sz == DEPTH) && !o;
         if (o && sz > 0) void'(mq.pop_front());
         if (p && (sz < DEPTH || o)) mq.push_back(d);
      end
      @(negedge clk);
      push = 1'b0; pop = 1'b0; clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
      #1;
      n_cmp++;
      if ({dout, cnt, full, empty, af, ae, ovf, unf} !== {2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state got out=%b cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b",
                  dout, cnt, full, empty, af, ae, ovf, unf);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_fill();
      logic [1:0] vals [4];
      vals[0] = 2'b11; vals[1] = 2'b10; vals[2] = 2'b11; vals[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 1'b0, vals[i]);
         n_cmp++;
         if ({cnt, af, full, dout} !== {3'(i + 1), (i + 1 >= 3), (i + 1 == 4), 2'b11}) begin
            n_err++;
            $display("FAIL fill_%0d got cnt=%0d af=%b full=%b out=%b", i, cnt, af, full, dout);
         end
      end
   endtask

   task automatic test_overflow();
      logic [1:0] exp [4];
      exp[0] = 2'b11; exp[1] = 2'b10; exp[2] = 2'b11; exp[3] = 2'b00;
      cycle(1'b1, 1'b0, 1'b0, 2'b01);
      n_cmp++;
      if ({ovf, cnt, full} !== {1'b1, 3'd4, 1'b1}) begin
         n_err++;
         $display("FAIL overflow_pulse got ovf=%b cnt=%0d full=%b exp ovf=1 cnt=4", ovf, cnt, full);
      end
      cycle(1'b0, 1'b0, 1'b0, 2'b00);
      n_cmp++;
      if (ovf !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_clears got ovf=%b exp 0", ovf);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dout !== exp[i]) begin
            n_err++;
            $display("FAIL ovf_drain_%0d got %b exp %b", i, dout, exp[i]);
         end
         cycle(1'b0, 1'b1, 1'b0, 2'b00);
      end
      n_cmp++;
      if ({empty, cnt, dout} !== {1'b1, 3'd0, 2'b00}) begin
         n_err++;
         $display("FAIL ovf_drain_empty got e=%b cnt=%0d out=%b", empty, cnt, dout);
      end
   endtask

   task automatic test_full_push_pop();
      logic [1:0] vals [4];
      logic [1:0] exp  [4];
      vals[0] = 2'b11; vals[1] = 2'b10; vals[2] = 2'b11; vals[3] = 2'b00;
      exp[0]  = 2'b10; exp[1]  = 2'b11; exp[2]  = 2'b00; exp[3]  = 2'b01;
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, vals[i]);
      cycle(1'b1, 1'b1, 1'b0, 2'b01);
      n_cmp++;
      if ({dout, cnt, ovf, full} !== {2'b10, 3'd4, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL full_push_pop got out=%b cnt=%0d ovf=%b full=%b exp out=10 cnt=4 ovf=0",
                  dout, cnt, ovf, full);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dout !== exp[i]) begin
            n_err++;
            $display("FAIL wrap_drain_%0d got %b exp %b", i, dout, exp[i]);
         end
         cycle(1'b0, 1'b1, 1'b0, 2'b00);
      end
   endtask

   task automatic test_underflow();
      cycle(1'b0, 1'b1, 1'b0, 2'b00);
      n_cmp++;
      if ({unf, cnt, dout, empty} !== {1'b1, 3'd0, 2'b00, 1'b1}) begin
         n_err++;
         $display("FAIL underflow_pulse got unf=%b cnt=%0d out=%b e=%b", unf, cnt, dout, empty);
      end
      cycle(1'b0, 1'b0, 1'b0, 2'b00);
      n_cmp++;
      if (unf !== 1'b0) begin
         n_err++;
         $display("FAIL underflow_clears got unf=%b exp 0", unf);
      end
      cycle(1'b1, 1'b1, 1'b0, 2'b10);
      n_cmp++;
      if ({unf, cnt, dout} !== {1'b1, 3'd1, 2'b10}) begin
         n_err++;
         $display("FAIL pop_push_empty got unf=%b cnt=%0d out=%b exp unf=1 cnt=1 out=10", unf, cnt, dout);
      end
      cycle(1'b0, 1'b1, 1'b0, 2'b00);
   endtask

   task automatic test_clear();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 2'(i + 1));
      n_cmp++;
      if (cnt !== 3'd3) begin
         n_err++;
         $display("FAIL clear_setup got cnt=%0d exp 3", cnt);
      end
      cycle(1'b1, 1'b1, 1'b1, 2'b11);
      n_cmp++;
      if ({cnt, empty, dout, ovf, unf} !== {3'd0, 1'b1, 2'b00, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL clear got cnt=%0d e=%b out=%b ovf=%b unf=%b", cnt, empty, dout, ovf, unf);
      end
      cycle(1'b0, 1'b1, 1'b1, 2'b00);
      n_cmp++;
      if (unf !== 1'b0) begin
         n_err++;
         $display("FAIL clear_masks_underflow got unf=%b exp 0", unf);
      end
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 1'b0, 1'b0, 2'b10);
      cycle(1'b1, 1'b0, 1'b0, 2'b11);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({cnt, empty, dout} !== {3'd0, 1'b1, 2'b00}) begin
         n_err++;
         $display("FAIL async_reset got cnt=%0d e=%b out=%b", cnt, empty, dout);
      end
      push = 1'b1; pop = 1'b0; din = 2'b11;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (cnt !== 3'd0) begin
         n_err++;
         $display("FAIL push_in_reset got cnt=%0d exp 0", cnt);
      end
      push = 1'b0;
      reset = 1'b1;
      mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 2'b01);
      n_cmp++;
      if ({dout, cnt} !== {2'b01, 3'd1}) begin
         n_err++;
         $display("FAIL push_after_reset got out=%b cnt=%0d exp out=01 cnt=1", dout, cnt);
      end
   endtask

   task automatic test_random();
      logic [10:0] expv;
      logic [10:0] gotv;
      int          sz;
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
               1'($urandom_range(0, 99) < 3), 2'($urandom));
         sz   = mq.size();
         expv = {(sz > 0) ? mq[0] : 2'b00, 3'(sz), (sz == DEPTH), (sz == 0),
                 (sz >= DEPTH - 1), (sz <= 1), m_ovf, m_unf};
         gotv = {dout, cnt, full, empty, af, ae, ovf, unf};
         n_cmp++;
         if (gotv !== expv) begin
            n_err++;
            $display("FAIL random_%0d got out,cnt,f,e,af,ae,ov,un=%b exp %b", i, gotv, expv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_full_push_pop();
      test_underflow();
      test_clear();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/fifo_thresh.md
FIFO_THRESH -- requirements
Module: fifo_thresh

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-002 Parameter WIDTH, default 2, data bits per entry.
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 1, almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous flush, active-high.
REQ-008 in  input  WIDTH  write data, sampled with push.
REQ-009 push  input  1  write request.
REQ-010 pop  input  1  read request.
REQ-011 out  output  WIDTH  head-of-queue data.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AF_LEVEL.
REQ-015 almost_empty  output  1  count <= AE_LEVEL.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 overflow  output  1  one-cycle pulse: push rejected.
REQ-018 underflow  output  1  one-cycle pulse: pop rejected.

Function
REQ-019 Storage SHALL be DEPTH x WIDTH registers with write pointer, read pointer and count registers; pointers wrap DEPTH-1 -> 0.
REQ-020 out SHALL be first-word-fall-through: combinationally equals entry at read pointer when not empty; all zeros when empty.
REQ-021 full, empty, almost_full, almost_empty SHALL be decoded combinationally from registered count only.
REQ-022 Accepted push SHALL write in at write pointer and advance it on the same edge; entry visible on out the cycle after write if queue was empty.
REQ-023 Accepted pop SHALL advance read pointer on the edge; next entry on out the following cycle.
REQ-024 push with full=1 and pop=0 SHALL be dropped; storage, pointers, count unchanged; overflow=1 for the following cycle.
REQ-025 pop with empty=1 SHALL be ignored; underflow=1 for the following cycle; a simultaneous push in that cycle is still accepted (no bypass).
REQ-026 push and pop together, 0 < count < DEPTH: both accepted, count unchanged.
REQ-027 push and pop together at full: pop accepted and push accepted, count stays DEPTH, no overflow.
REQ-028 clear=1 SHALL override push/pop: pointers and count to 0, no overflow/underflow pulse; storage contents need not be cleared.
REQ-029 overflow and underflow SHALL be registered, low in any cycle following one without a rejected request.
REQ-030 count arithmetic: +1 on push-only accept, -1 on pop-only accept, never outside 0..DEPTH.

Reset
REQ-031 reset low SHALL immediately (no clock needed) force pointers, count, overflow, underflow to 0, giving out=0, empty=1, almost_empty=1, full=0, almost_full=0, count=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued data; push/pop ignored while reset low.
REQ-033 First accepted operation SHALL occur on the first rising edge after reset deasserts.

Verification (DEPTH=4, WIDTH=2, AF_LEVEL=3, AE_LEVEL=1)
REQ-034 After reset, push 11,10,11,00 on four edges -> count 1,2,3,4; almost_full at count 3; full at 4; out=11 throughout.
REQ-035 At full, push 01 alone -> overflow pulses one cycle, count stays 4, later pops return 11,10,11,00 in order.
REQ-036 At full, push 01 with pop -> out goes 11->10, count 4, no overflow; subsequent pops return 10,11,00,01 (wrap-around verified).
REQ-037 Empty, pop alone -> underflow pulses one cycle, count 0, out=00; pop+push 10 while empty -> underflow pulse, count 1, out=10.
REQ-038 With count 3, assert clear -> next cycle count 0, empty=1, out=00, no error pulses.
REQ-039 With count 2, drive reset low between edges -> count 0, empty=1 immediately; after release push 01 -> out=01, count 1.
